// File: rtl/week6_ex1_logic_pipe.sv
// week6_ex1_logic_pipe
//
// Purpose:
//   Applies one of eight bitwise logic operations to two WIDTH-bit operands.
//   Results are queued in a DEPTH-entry first-word-fall-through FIFO.
//   The operand side and the result side each have a valid/ready handshake,
//   so the source and the consumer can stall independently.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   DEPTH  FIFO depth in entries (power of two, >= 2)
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   in_valid      operand beat offered
//   in_ready      block can accept a beat this cycle
//   op            operation select, sampled with the beat
//   a, b          operands
//   out_valid     head result available
//   out_ready     consumer takes the head result
//   out_y         head result (0 when empty)
//   level         number of stored entries
//   result_count  saturating count of completed pops
//                 (present only when LOGIC_PIPE_STATS_EN is defined)
//
// Optional feature macro: LOGIC_PIPE_STATS_EN
module week6_ex1_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
`ifdef LOGIC_PIPE_STATS_EN
  output logic [15:0]              result_count,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy; a full FIFO never lets a
  // beat through even when the consumer is popping in the same cycle.
  assign in_ready  = (level < LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is gated so a stale slot never shows on an empty FIFO.
  assign out_y = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOTA: result = ~a;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  // Storage: the computed result is written, not the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef LOGIC_PIPE_STATS_EN
  // Counts retired results and sticks at the maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_count <= '0;
    end else if (pop && (result_count != 16'hFFFF)) begin
      result_count <= result_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_week6_ex1_logic_pipe.sv
// tb_week6_ex1_logic_pipe
//
// Purpose:
//   Scoreboard bench for week6_ex1_logic_pipe (WIDTH=8, DEPTH=4).
//   The stimulus side queues the hand-computed result of every accepted beat.
//   A monitor on the falling edge retires queue entries whenever the DUT pops.
//   The monitor also tracks the expected occupancy.
//
// Ports: none (top-level bench).
// Optional feature macro: LOGIC_PIPE_STATS_EN
module tb_week6_ex1_logic_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [2:0] level;
`ifdef LOGIC_PIPE_STATS_EN
  logic [15:0] result_count;
`endif

  int         check_count = 0;
  int         error_count = 0;
  logic [7:0] exp_q[$];
  int         model_level = 0;
  int         pop_count = 0;

  week6_ex1_logic_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
`ifdef LOGIC_PIPE_STATS_EN
    .result_count (result_count),
`endif
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Offers one beat, holding it until accepted, and queues its expected result.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x,
                               input logic [7:0] y, input logic [7:0] exp);
    bit accepted = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain();
    bit empty = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && !empty; c++) begin
      @(negedge clk);
      if (level == 3'd0) empty = 1;
    end
    if (!empty) begin
      checkOutput("drain_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges and held across a falling edge so the
  // monitor flushes its model too.
  task automatic pulseReset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_y", 32'(out_y), 32'd0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: occupancy model, handshake flags and in-order result checking.
  always @(negedge clk) begin
    if (rst) begin
      model_level = 0;
      pop_count = 0;
      exp_q.delete();
    end else begin
      checkOutput("level", 32'(level), 32'(model_level));
      checkOutput("in_ready", 32'(in_ready), 32'(model_level < 4));
      checkOutput("out_valid", 32'(out_valid), 32'(model_level != 0));
      if (!out_valid) begin
        checkOutput("empty_out_y", 32'(out_y), 32'd0);
      end
`ifdef LOGIC_PIPE_STATS_EN
      checkOutput("result_count", 32'(result_count),
                  (pop_count > 65535) ? 32'd65535 : 32'(pop_count));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pop", 32'(out_y), 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_y", 32'(out_y), 32'(exp_q.pop_front()));
        end
        pop_count++;
        model_level--;
      end
      if (in_valid && in_ready) begin
        model_level++;
      end
    end
  end

  localparam logic [7:0] TT_EXP [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F,
                                        8'h03, 8'hC3, 8'h0F, 8'hF0};
  localparam logic [7:0] FILL_EXP [5] = '{8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    a = 8'd0;
    b = 8'd0;
    #3;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_y", 32'(out_y), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] truth table");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), 8'hF0, 8'hCC, TT_EXP[i]);
    end
    drain();

    $display("[TB] fill and stall");
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          applyStimulus(3'b011, 8'(i + 1), 8'(i + 1), FILL_EXP[i]);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        checkOutput("fill_level", 32'(level), 32'd4);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] simultaneous push and pop");
    out_ready = 1'b0;
    applyStimulus(3'b111, 8'h10, 8'h00, 8'h10);
    applyStimulus(3'b111, 8'h11, 8'h55, 8'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b111, 8'(8'h20 + i), 8'hAA, 8'(8'h20 + i));
      checkOutput("steady_level", 32'(level), 32'd2);
    end
    drain();

    $display("[TB] empty idle with ignored inputs");
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(7));
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    checkOutput("idle_level", 32'(level), 32'd0);
    checkOutput("idle_out_y", 32'(out_y), 32'd0);

    $display("[TB] async reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(3'b000, 8'h01, 8'h01, 8'h01);
    applyStimulus(3'b000, 8'h02, 8'h02, 8'h02);
    applyStimulus(3'b000, 8'h04, 8'h04, 8'h04);
    checkOutput("pre_reset_level", 32'(level), 32'd3);
    pulseReset();
    applyStimulus(3'b000, 8'hFF, 8'h0F, 8'h0F);
    drain();

`ifdef LOGIC_PIPE_STATS_EN
    $display("[TB] statistics counter");
    pulseReset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b111, 8'(i), 8'h00, 8'(i));
    end
    drain();
    checkOutput("count_six", 32'(result_count), 32'd6);
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(3'b001, 8'(i), 8'h00, 8'(i));
    end
    drain();
    checkOutput("count_saturated", 32'(result_count), 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/week6_ex1_logic_pipe.md
# week6_ex1_logic_pipe

- Parametrised, buffered successor to the single-bit NAND exercise.
- Applies one of eight bitwise logic operations to two WIDTH-bit operands and queues the results in a DEPTH-entry first-word-fall-through FIFO.
- Both operand input and result output use valid/ready handshakes.
- Sits between an operand source and a result consumer; either side may stall independently.

## Interface
- WIDTH, 8: operand/result width in bits (≥1).
- DEPTH, 4: result FIFO depth in entries; power of two, ≥2.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block can accept a beat this cycle.
- op  input  3  operation select, sampled with the beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  head result available.
- out_ready  input  1  consumer takes the head result.
- out_y  output  WIDTH  head result.
- level  output  $clog2(DEPTH)+1  current number of stored entries.

## Operation
- op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT a (b ignored)
  - 111 pass a
- Push: in_valid && in_ready at a rising edge writes f(op,a,b) into the tail entry. Computation is combinational on the sampled inputs; the result is stored, not the operands.
- in_ready = (level < DEPTH). It depends only on registered state, never on out_ready: no pass-through when full.
- Pop: out_valid && out_ready at a rising edge retires the head entry.
- out_valid = (level != 0).
- out_y holds the head entry whenever out_valid=1. It stays stable while out_valid && !out_ready. It is 0 when the FIFO is empty.
- Simultaneous push and pop:
  - With 0 < level < DEPTH: level is unchanged, and both pointers advance.
  - With level == DEPTH: the push is refused (in_ready=0) and only the pop occurs.
  - With level == 0: only the push occurs (out_valid=0).
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- The input side ignores in_valid=0 regardless of op/a/b values.
- Reset mid-operation discards all stored entries; no partial results survive.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_y=0
  - level=0
  - pointers=0
- Latency: a beat accepted at edge N is visible at the output after edge N with out_valid=1, i.e. in cycle N+1 (1-cycle latency) if the FIFO was empty.
- level updates on the same edge as the push/pop that changes it.
- Throughput: one push and one pop per cycle sustained.
- Reset assertion clears all state immediately, without waiting for clk. Deassertion takes effect at the next clk edge.

## Configuration
- LOGIC_PIPE_STATS_EN defined:
  - Adds output port result_count (16 bits): a saturating count of completed pops.
  - Resets to 0 and increments on each pop edge.
  - Holds at 16'hFFFF.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Truth table (WIDTH=8, DEPTH=4), a=8'hF0, b=8'hCC, out_ready=1, ops 000..111 on consecutive cycles -> out_y sequence C0, FC, 3C, 3F, 03, C3, 0F, F0, each one cycle after its push.
- Fill/stall: out_ready=0, push 5 beats with op=011 and a=b=8'h01..05 -> in_ready drops after the 4th accept and level=4. The 5th beat is held. Then out_ready=1 -> FE, FD, FC, FB appear in order, and the 5th beat is accepted once level<4.
- Simultaneous push/pop at level=2 -> level stays 2 and the order is preserved across pointer wrap over 10 beats.
- Empty: no pushes, out_ready=1 -> out_valid=0, out_y=0, level=0 for 20 cycles.
- Async reset with level=3, rst pulsed between edges -> immediately out_valid=0, level=0, in_ready=1. A subsequent push of op=000, a=8'hFF, b=8'h0F returns 0F.
- With LOGIC_PIPE_STATS_EN: after 6 pops result_count=6. Force 65540 pops -> result_count=16'hFFFF.
